// File: rtl/ahb_apb_gen2_pkg.sv
// Shared types for the AHB-Lite to APB3 bridge: AHB transfer/response codes and bridge FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ahb_apb_gen2_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP,
      ST_ERR1,
      ST_ERR2
   } bridge_state_t;

endpackage

// File: rtl/apb_slave_decoder.sv
// Maps the slave-index field of an address to a one-hot APB select plus an in-range flag.
// Latency: purely combinational.
// Backpressure: none.
// Ports: idx_i slave index field; sel_o one-hot select (all zero when out of range); vld_o index < NUM_SLAVES.
module apb_slave_decoder #(
   parameter int NUM_SLAVES = 3,
   parameter int SEL_W      = 2
) (
   input  logic [SEL_W-1:0]      idx_i,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic                  vld_o
);

   localparam int CMP_W = SEL_W + 1;

   always_comb begin
      sel_o = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_i == SEL_W'(i)) begin
            sel_o[i] = 1'b1;
         end
      end
   end

   // Extra bit keeps the compare correct when NUM_SLAVES is a power of two.
   assign vld_o = ({1'b0, idx_i} < CMP_W'(NUM_SLAVES));

endmodule

// File: rtl/ahb_apb_bridge_gen2.sv
// AHB-Lite slave to APB3 master bridge, one outstanding transfer, parametrised width and slave count.
// Latency: accept to Hreadyout=1 is 4 cycles plus one per Pready=0 cycle; errors answer in 2 cycles.
// Backpressure: Hreadyout low during WDATA/SETUP/ACCESS/ERR1; APB side stalls on Pready=0.
// Ports: AHB side clk/resetn/Hwrite/Hreadyin/Htrans/Haddr/Hwdata in, Hrdata/Hresp/Hreadyout out;
//        APB side Pselx/Penable/Pwrite/Paddr/Pwdata out, Prdata/Pready/Pslverr in.
// Optional: define APB_TIMEOUT_EN to abort ACCESS with an ERROR after TIMEOUT_CYCLES Pready=0 cycles.
module ahb_apb_bridge_gen2
   import ahb_apb_gen2_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_SLAVES     = 3,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  Hwrite,
   input  logic                  Hreadyin,
   input  logic [1:0]            Htrans,
   input  logic [ADDR_W-1:0]     Haddr,
   input  logic [DATA_W-1:0]     Hwdata,
   output logic [DATA_W-1:0]     Hrdata,
   output logic [1:0]            Hresp,
   output logic                  Hreadyout,
   output logic [NUM_SLAVES-1:0] Pselx,
   output logic                  Penable,
   output logic                  Pwrite,
   output logic [ADDR_W-1:0]     Paddr,
   output logic [DATA_W-1:0]     Pwdata,
   input  logic [DATA_W-1:0]     Prdata,
   input  logic                  Pready,
   input  logic                  Pslverr
);

   localparam int SEL_W = $clog2(NUM_SLAVES);

   if (NUM_SLAVES < 2 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("ahb_apb_bridge_gen2: unsupported parameter set");
   end

   bridge_state_t           state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    write_q, write_d;
   logic [NUM_SLAVES-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]       pwdata_q, pwdata_d;
   logic [DATA_W-1:0]       hrdata_q, hrdata_d;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_vld;
   htrans_t                 trans;
   hresp_t                  resp;
   logic                    accept;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

   apb_slave_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W)
   ) u_dec (
      .idx_i (Haddr[SEL_LSB +: SEL_W]),
      .sel_o (dec_sel),
      .vld_o (dec_vld)
   );

   assign trans  = htrans_t'(Htrans);
   assign accept = Hreadyin && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      write_d   = write_q;
      sel_d     = sel_q;
      pwdata_d  = pwdata_q;
      hrdata_d  = hrdata_q;
      Hreadyout = 1'b1;
      resp      = HRESP_OKAY;
      Pselx     = '0;
      Penable   = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         // RESP doubles as an address phase so back-to-back transfers see no gap.
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               addr_d  = Haddr;
               write_d = Hwrite;
               sel_d   = dec_sel;
               state_d = dec_vld ? ST_WDATA : ST_ERR1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WDATA: begin
            Hreadyout = 1'b0;
            if (write_q) begin
               pwdata_d = Hwdata;
            end
            state_d = ST_SETUP;
         end
         ST_SETUP: begin
            Hreadyout = 1'b0;
            Pselx     = sel_q;
            state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ST_ACCESS: begin
            Hreadyout = 1'b0;
            Pselx     = sel_q;
            Penable   = 1'b1;
            if (Pready) begin
               if (Pslverr) begin
                  state_d = ST_ERR1;
               end else begin
                  state_d = ST_RESP;
                  if (!write_q) begin
                     hrdata_d = Prdata;
                  end
               end
`ifdef APB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // This is the TIMEOUT_CYCLES-th stalled ACCESS cycle: give up.
               state_d = ST_ERR1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         ST_ERR1: begin
            Hreadyout = 1'b0;
            resp      = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            // Any transfer presented here is dropped; the master reissues it.
            resp    = HRESP_ERROR;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         sel_q    <= '0;
         pwdata_q <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         sel_q    <= sel_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign Hresp  = resp;
   assign Hrdata = hrdata_q;
   assign Paddr  = addr_q;
   assign Pwrite = write_q;
   assign Pwdata = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_gen2.sv
// Self-checking bench for ahb_apb_bridge_gen2: directed vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: Pready stalls driven per vector.
module tb_ahb_apb_bridge_gen2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        Hwrite = 1'b0;
   logic        Hreadyin = 1'b1;
   logic [1:0]  Htrans = 2'b00;
   logic [31:0] Haddr = '0;
   logic [31:0] Hwdata = '0;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        Hreadyout;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata = '0;
   logic        Pready = 1'b0;
   logic        Pslverr = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ahb_apb_bridge_gen2 dut (
      .clk       (clk),
      .resetn    (resetn),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Htrans    (Htrans),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Hrdata    (Hrdata),
      .Hresp     (Hresp),
      .Hreadyout (Hreadyout),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Prdata    (Prdata),
      .Pready    (Pready),
      .Pslverr   (Pslverr)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      logic        slverr;
      logic        dec_err;
      logic [2:0]  exp_sel;
      logic [31:0] exp_pwdata;
      logic [31:0] exp_hrdata;
      logic [1:0]  exp_hresp;
   } vec_t;

   vec_t vecs[7];
   vec_t b2b[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one transfer. pre=1 means the caller is already at the negedge of a RESP cycle
   // and the new address phase is presented right there.
   task automatic run_vec(input vec_t v, input bit pre);
      int acc;
      if (!pre) begin
         @(negedge clk);
         chk("idle_rdy", Hreadyout, 1);
         chk("idle_resp", Hresp, 0);
      end
      Htrans   = 2'b10;
      Hreadyin = 1'b1;
      Haddr    = v.addr;
      Hwrite   = v.wr;
      @(negedge clk);
      Htrans = 2'b00;
      Haddr  = '0;
      Hwrite = 1'b0;
      Hwdata = v.wdata;
      chk("accept_rdy", Hreadyout, 0);
      chk("accept_nosel", Pselx, 0);
      if (v.dec_err) begin
         chk("derr1_resp", Hresp, v.exp_hresp);
         @(negedge clk);
         chk("derr2_rdy", Hreadyout, 1);
         chk("derr2_resp", Hresp, 1);
         chk("derr2_nosel", Pselx, 0);
         chk("derr_hrdata", Hrdata, v.exp_hrdata);
         return;
      end
      @(negedge clk);
      chk("setup_sel", Pselx, v.exp_sel);
      chk("setup_pen", Penable, 0);
      chk("setup_paddr", Paddr, v.addr);
      chk("setup_pwrite", Pwrite, v.wr);
      chk("setup_rdy", Hreadyout, 0);
      Prdata  = v.rdata;
      Pslverr = v.slverr;
      acc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!Penable) break;
         acc++;
         chk("access_sel", Pselx, v.exp_sel);
         Pready = (acc > v.waits);
      end
      Pready  = 1'b0;
      Pslverr = 1'b0;
      chk("access_len", acc, v.waits + 1);
      chk("pwdata", Pwdata, v.exp_pwdata);
      chk("end_resp", Hresp, v.exp_hresp);
      chk("end_nosel", Pselx, 0);
      if (v.exp_hresp == 2'b00) begin
         chk("resp_rdy", Hreadyout, 1);
      end else begin
         chk("err1_rdy", Hreadyout, 0);
         @(negedge clk);
         chk("err2_rdy", Hreadyout, 1);
         chk("err2_resp", Hresp, 1);
      end
      chk("hrdata", Hrdata, v.exp_hrdata);
   endtask

   initial begin
      int acc;
      //             wr    addr          wdata         rdata         w  err   dec   sel     pwdata        hrdata        hresp
      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b0, 3'b001, 32'hDEAD_BEEF, 32'h0,        2'b00};
      vecs[1] = '{1'b0, 32'h0000_2004, 32'hFFFF_FFFF, 32'h1234_5678, 2, 1'b0, 1'b0, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678, 2'b00};
      vecs[2] = '{1'b1, 32'h0000_1008, 32'hA5A5_0001, 32'h0,        0, 1'b1, 1'b0, 3'b010, 32'hA5A5_0001, 32'h1234_5678, 2'b01};
      vecs[3] = '{1'b0, 32'h0000_3000, 32'h0,        32'h0,        0, 1'b0, 1'b1, 3'b000, 32'hA5A5_0001, 32'h1234_5678, 2'b01};
      vecs[4] = '{1'b0, 32'h0000_1FFC, 32'h0,        32'hCAFE_F00D, 1, 1'b0, 1'b0, 3'b010, 32'hA5A5_0001, 32'hCAFE_F00D, 2'b00};
      vecs[5] = '{1'b0, 32'h0000_2100, 32'h0,        32'h1111_1111, 3, 1'b1, 1'b0, 3'b100, 32'hA5A5_0001, 32'hCAFE_F00D, 2'b01};
      vecs[6] = '{1'b1, 32'h0000_0FFC, 32'h0000_0001, 32'h0,        0, 1'b0, 1'b0, 3'b001, 32'h0000_0001, 32'hCAFE_F00D, 2'b00};
      b2b[0]  = '{1'b1, 32'h0000_0004, 32'h1111_2222, 32'h0,        0, 1'b0, 1'b0, 3'b001, 32'h1111_2222, 32'hCAFE_F00D, 2'b00};
      b2b[1]  = '{1'b0, 32'h0000_1000, 32'h0,        32'h0BAD_F00D, 0, 1'b0, 1'b0, 3'b010, 32'h1111_2222, 32'h0BAD_F00D, 2'b00};

      // Reset values
      #12;
      chk("rst_rdy", Hreadyout, 1);
      chk("rst_resp", Hresp, 0);
      chk("rst_hrdata", Hrdata, 0);
      chk("rst_sel", Pselx, 0);
      chk("rst_pen", Penable, 0);
      chk("rst_pwrite", Pwrite, 0);
      chk("rst_paddr", Paddr, 0);
      chk("rst_pwdata", Pwdata, 0);
      @(negedge clk);
      resetn = 1'b1;

      // BUSY and not-ready NONSEQ must be ignored
      @(negedge clk);
      Htrans = 2'b01; Haddr = 32'h10; Hreadyin = 1'b1;
      @(negedge clk);
      chk("busy_ignored", Hreadyout, 1);
      Htrans = 2'b10; Hreadyin = 1'b0;
      @(negedge clk);
      chk("noready_ignored", Hreadyout, 1);
      chk("noready_nosel", Pselx, 0);
      Htrans = 2'b00; Hreadyin = 1'b1; Haddr = '0;

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], 1'b0);
      end

      // Back-to-back: second NONSEQ presented in the RESP cycle
      run_vec(b2b[0], 1'b0);
      run_vec(b2b[1], 1'b1);

      // Long Pready stall
      @(negedge clk);
      Htrans = 2'b10; Haddr = 32'h0000_0008; Hwrite = 1'b0;
      @(negedge clk);
      Htrans = 2'b00; Haddr = '0;
      @(negedge clk);
      Prdata = 32'h600D_CAFE; Pready = 1'b0;
      acc = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!Penable) break;
         acc++;
      end
`ifdef APB_TIMEOUT_EN
      chk("to_len", acc, 16);
      chk("to_resp", Hresp, 1);
      chk("to_rdy", Hreadyout, 0);
      chk("to_nosel", Pselx, 0);
      @(negedge clk);
      chk("to_err2_rdy", Hreadyout, 1);
      chk("to_hrdata", Hrdata, 32'h0BAD_F00D);
`else
      chk("stall_len", acc, 30);
      chk("stall_sel", Pselx, 3'b001);
      Pready = 1'b1;
      @(negedge clk);
      Pready = 1'b0;
      chk("stall_done_rdy", Hreadyout, 1);
      chk("stall_done_resp", Hresp, 0);
      chk("stall_hrdata", Hrdata, 32'h600D_CAFE);
`endif

      // Reset asserted mid-ACCESS
      @(negedge clk);
      Htrans = 2'b10; Haddr = 32'h0000_2000; Hwrite = 1'b0;
      @(negedge clk);
      Htrans = 2'b00; Haddr = '0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_pen", Penable, 1);
      resetn = 1'b0;
      #1;
      chk("midrst_sel", Pselx, 0);
      chk("midrst_pen", Penable, 0);
      chk("midrst_rdy", Hreadyout, 1);
      chk("midrst_resp", Hresp, 0);
      chk("midrst_paddr", Paddr, 0);
      chk("midrst_hrdata", Hrdata, 0);
      @(negedge clk);
      resetn = 1'b1;
      run_vec(vecs[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ahb_apb_bridge_gen2.md
Name: ahb_apb_bridge_gen2

Overview:
Parametrised AHB-Lite slave to APB3 master bridge; successor to the fixed 32-bit, 3-slave bridge.
- Generalises address/data width and APB slave count.
- Adds APB3 wait states (Pready), slave error (Pslverr) mapped to a 2-cycle AHB ERROR response, and decode-error handling.
- Sits between the AHB interconnect and the APB peripheral cluster; one outstanding transfer.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, data width
NUM_SLAVES, 3, APB slave count (2..16); Pselx width
SEL_LSB, 12, lowest Haddr bit of slave-index field; field width SEL_W = $clog2(NUM_SLAVES) (localparam)
TIMEOUT_CYCLES, 16, ACCESS-phase watchdog limit (used only with optional feature)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
Hwrite  in  1  AHB write
Hreadyin  in  1  AHB bus ready
Htrans  in  2  AHB transfer type
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (data phase)
Hrdata  out  DATA_W  AHB read data
Hresp  out  2  AHB response (00 OKAY, 01 ERROR)
Hreadyout  out  1  AHB ready
Pselx  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB enable
Pwrite  out  1  APB write
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on resetn.
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, state=IDLE.
- Assertion of resetn low mid-transfer clears outputs immediately and drops the transfer.
- Accept condition: Hreadyin=1 and Htrans[1]=1 (NONSEQ/SEQ), sampled only in IDLE or RESP. IDLE/BUSY transfer types are ignored.
- On accept, register Haddr, Hwrite and slave index idx = Haddr[SEL_LSB +: SEL_W].
- State machine: IDLE, WDATA, SETUP, ACCESS, RESP, ERR1, ERR2.
- IDLE: Hreadyout=1, no APB activity.
  - Accept with idx < NUM_SLAVES -> WDATA.
  - Accept with idx >= NUM_SLAVES -> ERR1 (decode error, no APB access).
- WDATA (AHB data phase, Hreadyout=0): capture Hwdata into Pwdata if write -> SETUP.
- SETUP: Pselx[idx]=1, Penable=0, Paddr/Pwrite driven -> ACCESS.
- ACCESS: Pselx held, Penable=1; all APB outputs stable.
  - Pready=0: stay.
  - Pready=1, Pslverr=0 -> RESP; on a read, latch Prdata into Hrdata at the same edge.
  - Pready=1, Pslverr=1 -> ERR1.
- RESP: Hreadyout=1, Hresp=00, Pselx=0, Penable=0.
  - Accept -> WDATA/ERR1 as in IDLE (back-to-back); otherwise -> IDLE.
- ERR1: Hreadyout=0, Hresp=01, APB idle -> ERR2.
- ERR2: Hreadyout=1, Hresp=01 -> IDLE. A transfer presented in ERR2 is dropped; the master must reissue it.
- Hreadyout is 0 in WDATA/SETUP/ACCESS/ERR1.
- Minimum latency: accept edge to Hreadyout=1 is 4 cycles (WDATA, SETUP, ACCESS, RESP); each Pready=0 cycle adds 1.
- Hrdata holds its last value on writes and errors.
- Pwdata holds its last value on reads.

Optional Feature:
APB_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with Pready=0. Reaching TIMEOUT_CYCLES forces ACCESS -> ERR1 and deasserts Pselx/Penable.
- Undefined: no counter; ACCESS waits indefinitely for Pready.

Decomposition:
- Package ahb_apb_gen2_pkg:
  - htrans_t enum (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
  - hresp_t (OKAY=00, ERROR=01)
  - bridge_state_t enum
- Sub-module apb_slave_decoder (combinational): idx -> one-hot select plus valid flag, parametrised by NUM_SLAVES.

Test Plan:
- Write 0xDEADBEEF to Haddr 0x0000_0010 (idx 0), Pready=1 -> Pselx=001, Paddr=0x10, Pwdata=0xDEADBEEF, Penable for 1 cycle, Hreadyout=1 four cycles after accept, Hresp=00.
- Read Haddr 0x0000_2004 (idx 2), Pready low 2 cycles, Prdata=0x1234_5678 -> ACCESS lasts 3 cycles, Hrdata=0x1234_5678 in RESP, Hresp=00.
- Write to idx 1 with Pready=1, Pslverr=1 -> Hresp=01 with Hreadyout=0 then 1, then IDLE.
- Read Haddr 0x0000_3000 (idx 3, NUM_SLAVES=3) -> no Pselx asserted, 2-cycle ERROR response.
- Back-to-back NONSEQ write then read presented in RESP cycle -> second transfer accepted with no IDLE gap.
- resetn low during ACCESS -> Pselx=0, Penable=0, Hreadyout=1 immediately. With APB_TIMEOUT_EN, Pready held 0 -> ERROR after 16 ACCESS cycles.
